// File: rtl/rnd_sat_pipe.sv
// Two-stage rounding/saturating width reducer with a valid/ready handshake
// and a sticky count of saturated output transfers.
module rnd_sat_pipe #(
    parameter int IN_WID  = 16,
    parameter int OUT_WID = 10,
    parameter int SIGNED  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_WID-1:0]  i_data,
    input  logic [1:0]         i_mode,
    input  logic               i_valid,
    output logic               i_ready,
    output logic [OUT_WID-1:0] o_data,
    output logic               o_sat,
    output logic               o_valid,
    input  logic               o_ready,
    input  logic               clr_cnt,
    output logic [15:0]        sat_cnt
);

    localparam int T     = IN_WID - OUT_WID;
    localparam int SW    = IN_WID + 2;
    localparam int QW    = SW - T;
    localparam int H_INT = 1 << (T - 1);
    localparam logic signed [SW-1:0] H    = SW'(H_INT);
    localparam logic signed [SW-1:0] H_M1 = SW'(H_INT - 1);
    localparam logic signed [QW-1:0] Q_MAX = (SIGNED != 0) ?
        QW'((1 << (OUT_WID - 1)) - 1) : QW'((1 << OUT_WID) - 1);

    logic                 ext_bit;
    logic signed [SW-1:0] x_ext;
    logic signed [SW-1:0] bias;
    logic signed [SW-1:0] sum;
    logic signed [QW-1:0] q_new;
    logic                 s2_adv;
    logic                 s1_adv;

    logic                 s1_valid_d, s1_valid_q;
    logic signed [QW-1:0] s1_q_d, s1_q_q;
    logic                 o_valid_d, o_valid_q;
    logic [OUT_WID-1:0]   o_data_d, o_data_q;
    logic                 o_sat_d, o_sat_q;
    logic [15:0]          sat_cnt_d, sat_cnt_q;

    // Two guard bits keep an unsigned full-scale sample plus bias positive,
    // so the arithmetic shift never sees a false sign.
    always_comb begin
        ext_bit = (SIGNED != 0) && i_data[IN_WID-1];
        x_ext   = {{2{ext_bit}}, i_data};
        bias    = '0;
        unique case (i_mode)
            2'b00: bias = '0;
            2'b01: bias = H;
            2'b10: bias = H_M1 + SW'(i_data[T]);
            2'b11: bias = ext_bit ? H_M1 : H;
        endcase
        sum   = x_ext + bias;
        q_new = QW'(sum >>> T);
    end

    always_comb begin
        s2_adv = !o_valid_q || o_ready;
        s1_adv = !s1_valid_q || s2_adv;

        s1_valid_d = s1_adv ? i_valid : s1_valid_q;
        s1_q_d     = (s1_adv && i_valid) ? q_new : s1_q_q;

        o_valid_d = s2_adv ? s1_valid_q : o_valid_q;
        o_data_d  = o_data_q;
        o_sat_d   = o_sat_q;
        // q is never negative below the signed minimum, so only the top clamp exists.
        if (s2_adv && s1_valid_q) begin
            if (s1_q_q > Q_MAX) begin
                o_data_d = Q_MAX[OUT_WID-1:0];
                o_sat_d  = 1'b1;
            end else begin
                o_data_d = s1_q_q[OUT_WID-1:0];
                o_sat_d  = 1'b0;
            end
        end

        sat_cnt_d = sat_cnt_q;
        if (clr_cnt) begin
            sat_cnt_d = '0;
        end else if (o_valid_q && o_ready && o_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q_q     <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_sat_q    <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q_q     <= s1_q_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_sat_q    <= o_sat_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign i_ready = s1_adv;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sat   = o_sat_q;
    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_rnd_sat_pipe.sv
// Bench for rnd_sat_pipe: unsigned and signed instances share one stimulus
// stream; a scoreboard queue holds the expected result of every accepted sample.
module tb_rnd_sat_pipe;

    typedef struct {
        logic [9:0] ud;
        logic       us;
        logic [9:0] sd;
        logic       ss;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [9:0]  ud;
        logic        us;
        logic [9:0]  sd;
        logic        ss;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_data;
    logic [1:0]  i_mode;
    logic        i_valid;
    logic        o_ready;
    logic        clr_cnt;
    logic        i_ready_u, i_ready_s;
    logic [9:0]  o_data_u, o_data_s;
    logic        o_sat_u, o_sat_s;
    logic        o_valid_u, o_valid_s;
    logic [15:0] sat_cnt_u, sat_cnt_s;

    exp_t        sb[$];
    exp_t        cur_exp;
    exp_t        mon_e;
    logic [15:0] mon_sat_u, mon_sat_s;
    int          n_vec;
    int          n_err;

    rnd_sat_pipe #(.IN_WID(16), .OUT_WID(10), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_mode(i_mode),
        .i_valid(i_valid), .i_ready(i_ready_u), .o_data(o_data_u),
        .o_sat(o_sat_u), .o_valid(o_valid_u), .o_ready(o_ready),
        .clr_cnt(clr_cnt), .sat_cnt(sat_cnt_u)
    );

    rnd_sat_pipe #(.IN_WID(16), .OUT_WID(10), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_mode(i_mode),
        .i_valid(i_valid), .i_ready(i_ready_s), .o_data(o_data_s),
        .o_sat(o_sat_s), .o_valid(o_valid_s), .o_ready(o_ready),
        .clr_cnt(clr_cnt), .sat_cnt(sat_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // Integer reference for one rounding at T=6, OUT_WID=10.
    function automatic void rnd(input int x, input logic [1:0] m, input logic sgn,
                                input logic b6, output logic [9:0] d, output logic s);
        int b;
        int q;
        int mx;
        case (m)
            2'd0:    b = 0;
            2'd1:    b = 32;
            2'd2:    b = b6 ? 32 : 31;
            default: b = (sgn && x < 0) ? 31 : 32;
        endcase
        q  = (x + b) >>> 6;
        mx = sgn ? 511 : 1023;
        if (q > mx) begin
            d = mx[9:0];
            s = 1'b1;
        end else begin
            d = q[9:0];
            s = 1'b0;
        end
    endfunction

    function automatic exp_t model(input logic [15:0] d, input logic [1:0] m);
        exp_t e;
        int   xu;
        int   xs;
        xu = int'({16'h0000, d});
        xs = int'($signed(d));
        rnd(xu, m, 1'b0, d[6], e.ud, e.us);
        rnd(xs, m, 1'b1, d[6], e.sd, e.ss);
        return e;
    endfunction

    function automatic logic [15:0] pick_data();
        case ($urandom_range(0, 7))
            0:       return 16'hFFE0 | 16'($urandom_range(0, 31));
            1:       return 16'h7FE0 | 16'($urandom_range(0, 31));
            2:       return 16'h8000 | 16'($urandom_range(0, 127));
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid_u && o_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: output %h/%h appeared with nothing expected", o_data_u, o_data_s);
                end else begin
                    mon_e = sb.pop_front();
                    if ({o_data_u, o_sat_u, o_data_s, o_sat_s} !== {mon_e.ud, mon_e.us, mon_e.sd, mon_e.ss}) begin
                        n_err++;
                        $display("FAIL sb_data: got u=%h sat=%b s=%h sat=%b, expected u=%h sat=%b s=%h sat=%b",
                                 o_data_u, o_sat_u, o_data_s, o_sat_s, mon_e.ud, mon_e.us, mon_e.sd, mon_e.ss);
                    end
                    if (mon_e.us && mon_sat_u != 16'hFFFF) mon_sat_u++;
                    if (mon_e.ss && mon_sat_s != 16'hFFFF) mon_sat_s++;
                end
            end
            if (i_valid && i_ready_u) sb.push_back(cur_exp);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b0; clr_cnt = 1'b0;
        i_data = '0; i_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({o_valid_u, o_valid_s} !== 2'b00) begin
            n_err++; $display("FAIL reset_valid: got %b required 00", {o_valid_u, o_valid_s});
        end
        n_vec++;
        if ({o_data_u, o_sat_u, o_data_s, o_sat_s} !== 22'd0) begin
            n_err++; $display("FAIL reset_data: got %h/%b %h/%b required zeros", o_data_u, o_sat_u, o_data_s, o_sat_s);
        end
        n_vec++;
        if ({sat_cnt_u, sat_cnt_s} !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt: got %h %h required 0000", sat_cnt_u, sat_cnt_s);
        end
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({i_ready_u, i_ready_s} !== 2'b11) begin
            n_err++; $display("FAIL reset_ready: got %b required 11", {i_ready_u, i_ready_s});
        end
    endtask

    task automatic test_rounding_table();
        vec_t tv[19];
        tv[0]  = '{16'h0020, 2'd1, 10'h001, 1'b0, 10'h001, 1'b0};
        tv[1]  = '{16'h0060, 2'd1, 10'h002, 1'b0, 10'h002, 1'b0};
        tv[2]  = '{16'h00A0, 2'd1, 10'h003, 1'b0, 10'h003, 1'b0};
        tv[3]  = '{16'h0020, 2'd2, 10'h000, 1'b0, 10'h000, 1'b0};
        tv[4]  = '{16'h0060, 2'd2, 10'h002, 1'b0, 10'h002, 1'b0};
        tv[5]  = '{16'h00A0, 2'd2, 10'h002, 1'b0, 10'h002, 1'b0};
        tv[6]  = '{16'h0020, 2'd0, 10'h000, 1'b0, 10'h000, 1'b0};
        tv[7]  = '{16'h0060, 2'd0, 10'h001, 1'b0, 10'h001, 1'b0};
        tv[8]  = '{16'h00A0, 2'd0, 10'h002, 1'b0, 10'h002, 1'b0};
        tv[9]  = '{16'hFFE0, 2'd1, 10'h3FF, 1'b1, 10'h000, 1'b0};
        tv[10] = '{16'hFFE0, 2'd0, 10'h3FF, 1'b0, 10'h3FF, 1'b0};
        tv[11] = '{16'hFFE0, 2'd3, 10'h3FF, 1'b1, 10'h3FF, 1'b0};
        tv[12] = '{16'h7FE0, 2'd1, 10'h200, 1'b0, 10'h1FF, 1'b1};
        tv[13] = '{16'h8000, 2'd0, 10'h200, 1'b0, 10'h200, 1'b0};
        tv[14] = '{16'h7FFF, 2'd3, 10'h200, 1'b0, 10'h1FF, 1'b1};
        tv[15] = '{16'hFFFF, 2'd2, 10'h3FF, 1'b1, 10'h000, 1'b0};
        tv[16] = '{16'h0FE0, 2'd2, 10'h040, 1'b0, 10'h040, 1'b0};
        tv[17] = '{16'hFFA0, 2'd2, 10'h3FE, 1'b0, 10'h3FE, 1'b0};
        tv[18] = '{16'hFFA0, 2'd3, 10'h3FF, 1'b0, 10'h3FE, 1'b0};
        o_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            i_data = tv[i].d; i_mode = tv[i].m;
            cur_exp = '{tv[i].ud, tv[i].us, tv[i].sd, tv[i].ss};
            i_valid = 1'b1;
            @(posedge clk); #1;
            i_valid = 1'b0;
            n_vec++;
            if (o_valid_u !== 1'b0) begin
                n_err++; $display("FAIL latency_early vec %0d: o_valid got %b required 0", i, o_valid_u);
            end
            @(posedge clk); #1;
            n_vec++;
            if ({o_valid_u, o_valid_s} !== 2'b11) begin
                n_err++; $display("FAIL latency_two vec %0d: o_valid got %b required 11", i, {o_valid_u, o_valid_s});
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL table_drain: %0d left required 0", sb.size());
        end
        n_vec++;
        if ({sat_cnt_u, sat_cnt_s} !== {16'd3, 16'd2}) begin
            n_err++; $display("FAIL table_satcnt: got %0d/%0d required 3/2", sat_cnt_u, sat_cnt_s);
        end
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        n_vec++;
        if ({sat_cnt_u, sat_cnt_s} !== 32'd0) begin
            n_err++; $display("FAIL clr_cnt: got %0d/%0d required 0/0", sat_cnt_u, sat_cnt_s);
        end
    endtask

    task automatic test_stall();
        int          acc;
        logic [9:0]  prev_u;
        logic [9:0]  prev_s;
        acc = 0;
        prev_u = '0;
        prev_s = '0;
        for (int c = 0; c < 30; c++) begin
            o_ready = !(c >= 3 && c <= 6);
            if (acc < 8) begin
                i_valid = 1'b1; i_data = pick_data(); i_mode = 2'($urandom_range(0, 3));
                cur_exp = model(i_data, i_mode);
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            if (i_valid && i_ready_u) acc++;
            if (c >= 3 && c <= 6) begin
                n_vec++;
                if ({i_ready_u, i_ready_s} !== 2'b00) begin
                    n_err++; $display("FAIL stall_ready c%0d: got %b required 00", c, {i_ready_u, i_ready_s});
                end
            end
            if (c >= 4 && c <= 6) begin
                n_vec++;
                if ({o_valid_u, o_data_u, o_data_s} !== {1'b1, prev_u, prev_s}) begin
                    n_err++; $display("FAIL stall_hold c%0d: got %b %h %h required 1 %h %h",
                                      c, o_valid_u, o_data_u, o_data_s, prev_u, prev_s);
                end
            end
            prev_u = o_data_u;
            prev_s = o_data_s;
            @(posedge clk); #1;
        end
        n_vec++;
        if (acc != 8 || sb.size() != 0) begin
            n_err++; $display("FAIL stall_count: accepted %0d pending %0d required 8 and 0", acc, sb.size());
        end
    endtask

    task automatic test_random_backpressure();
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        mon_sat_u = '0;
        mon_sat_s = '0;
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            o_ready = ($urandom_range(0, 3) != 0);
            i_data  = pick_data();
            i_mode  = 2'($urandom_range(0, 3));
            cur_exp = model(i_data, i_mode);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL random_drain: %0d left required 0", sb.size());
        end
        n_vec++;
        if ({sat_cnt_u, sat_cnt_s} !== {mon_sat_u, mon_sat_s}) begin
            n_err++; $display("FAIL random_satcnt: got %0d/%0d required %0d/%0d", sat_cnt_u, sat_cnt_s, mon_sat_u, mon_sat_s);
        end
    endtask

    task automatic test_sat_counter();
        int n;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        i_data = 16'hFFE0; i_mode = 2'd1; o_ready = 1'b1;
        cur_exp = '{10'h3FF, 1'b1, 10'h000, 1'b0};
        i_valid = 1'b1;
        n = 0;
        for (int k = 0; k < 70000 && n < 65537; k++) begin
            @(negedge clk);
            if (o_valid_u && o_ready) n++;
        end
        #1 i_valid = 1'b0;
        n_vec++;
        if (n != 65537) begin
            n_err++; $display("FAIL satcnt_budget: got %0d transfers required 65537", n);
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if ({sat_cnt_u, sat_cnt_s} !== {16'hFFFF, 16'h0000}) begin
            n_err++; $display("FAIL satcnt_hold: got %h/%h required FFFF/0000", sat_cnt_u, sat_cnt_s);
        end
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({o_valid_u, o_sat_u} !== 2'b11) begin
            n_err++; $display("FAIL satcnt_pre: o_valid/o_sat got %b required 11", {o_valid_u, o_sat_u});
        end
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        n_vec++;
        if (sat_cnt_u !== 16'h0000) begin
            n_err++; $display("FAIL satcnt_clr_prio: got %h required 0000", sat_cnt_u);
        end
    endtask

    task automatic test_reset_midflight();
        logic stale;
        o_ready = 1'b0;
        i_valid = 1'b1; i_data = pick_data(); i_mode = 2'($urandom_range(0, 3));
        cur_exp = model(i_data, i_mode);
        @(posedge clk); #1;
        i_data = pick_data(); cur_exp = model(i_data, i_mode);
        @(posedge clk); #1;
        i_valid = 1'b0;
        n_vec++;
        if ({o_valid_u, i_ready_u} !== 2'b10) begin
            n_err++; $display("FAIL midrst_full: o_valid/i_ready got %b required 10", {o_valid_u, i_ready_u});
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_valid_u, o_valid_s, o_data_u, o_sat_u} !== 13'd0) begin
            n_err++; $display("FAIL midrst_async: got v=%b%b d=%h s=%b required zeros", o_valid_u, o_valid_s, o_data_u, o_sat_u);
        end
        sb.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        o_ready = 1'b1;
        stale = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (o_valid_u || o_valid_s) stale = 1'b1;
        end
        n_vec++;
        if (stale !== 1'b0) begin
            n_err++; $display("FAIL midrst_stale: stale output seen got 1 required 0");
        end
        i_valid = 1'b1; i_data = 16'h00A0; i_mode = 2'd1;
        cur_exp = '{10'h003, 1'b0, 10'h003, 1'b0};
        @(posedge clk); #1;
        i_valid = 1'b0;
        n_vec++;
        if (o_valid_u !== 1'b0) begin
            n_err++; $display("FAIL midrst_lat1: o_valid got %b required 0", o_valid_u);
        end
        @(posedge clk); #1;
        n_vec++;
        if (o_valid_u !== 1'b1) begin
            n_err++; $display("FAIL midrst_lat2: o_valid got %b required 1", o_valid_u);
        end
        @(posedge clk); #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL midrst_drain: %0d left required 0", sb.size());
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        mon_sat_u = '0;
        mon_sat_s = '0;
        cur_exp = '{10'h000, 1'b0, 10'h000, 1'b0};
        test_reset();
        test_rounding_table();
        test_stall();
        test_random_backpressure();
        test_sat_counter();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
